// File: rtl/reorder_buffer.sv
// Circular in-order retirement queue: allocates ROB ids at dispatch, captures CDB results,
// retires the head to the register file and flushes everything on a branch mispredict.
module reorder_buffer #(
  parameter int unsigned ROB_SIZE = 16,
  parameter int unsigned ROB_ID_W = 5,
  parameter int unsigned REG_W    = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable_sign_from_cmd,
  input  logic [REG_W-1:0]    rd_from_cmd,
  input  logic                is_branch_from_cmd,
  input  logic                pred_jump_from_cmd,
  input  logic [31:0]         alt_pc_from_cmd,
  output logic [ROB_ID_W-1:0] rob_id_to_cmd,
  output logic                full_to_cmd,
  input  logic [ROB_ID_W-1:0] query1_id_from_cmd,
  input  logic [ROB_ID_W-1:0] query2_id_from_cmd,
  output logic                query1_ready_to_cmd,
  output logic [31:0]         query1_V_to_cmd,
  output logic                query2_ready_to_cmd,
  output logic [31:0]         query2_V_to_cmd,
  input  logic                valid_from_cdb,
  input  logic [ROB_ID_W-1:0] rob_id_from_cdb,
  input  logic [31:0]         V_from_cdb,
  input  logic                jump_from_cdb,
  output logic                commit_sign_to_reg,
  output logic [REG_W-1:0]    rd_to_reg,
  output logic [31:0]         V_to_reg,
  output logic [ROB_ID_W-1:0] Q_to_reg,
  output logic                rollback_sign_to_reg,
  output logic [31:0]         target_pc_to_if
);

  localparam int unsigned PtrW = $clog2(ROB_SIZE);
  localparam int unsigned CntW = $clog2(ROB_SIZE + 1);

  logic [PtrW-1:0]     head_q, head_d, tail_q, tail_d;
  logic [CntW-1:0]     count_q, count_d;

  logic [ROB_SIZE-1:0] busy_q, busy_d;
  logic [ROB_SIZE-1:0] ready_q, ready_d;
  logic [ROB_SIZE-1:0] is_branch_q, is_branch_d;
  logic [ROB_SIZE-1:0] pred_jump_q, pred_jump_d;
  logic [ROB_SIZE-1:0] actual_jump_q, actual_jump_d;
  logic [REG_W-1:0]    rd_q     [ROB_SIZE];
  logic [REG_W-1:0]    rd_d     [ROB_SIZE];
  logic [31:0]         alt_pc_q [ROB_SIZE];
  logic [31:0]         alt_pc_d [ROB_SIZE];
  logic [31:0]         v_q      [ROB_SIZE];
  logic [31:0]         v_d      [ROB_SIZE];

  logic                commit_q, commit_d;
  logic                rollback_q, rollback_d;
  logic [REG_W-1:0]    rd_reg_q, rd_reg_d;
  logic [31:0]         v_reg_q, v_reg_d;
  logic [ROB_ID_W-1:0] q_reg_q, q_reg_d;
  logic [31:0]         target_pc_q, target_pc_d;

  logic                retire_valid, mispredict, flush, commit_ok, alloc;
  logic [ROB_ID_W-1:0] cdb_m1;
  logic [PtrW-1:0]     cdb_idx;
  logic                cdb_in_range, cdb_hit;

  logic [ROB_ID_W-1:0] qid    [2];
  logic [ROB_ID_W-1:0] q_m1   [2];
  logic [PtrW-1:0]     q_idx  [2];
  logic                q_rdy  [2];
  logic [31:0]         q_val  [2];

  assign full_to_cmd   = (count_q == CntW'(ROB_SIZE));
  assign rob_id_to_cmd = ROB_ID_W'(tail_q) + ROB_ID_W'(1);

  // Retire looks only at registered readiness; a same-cycle CDB result waits one cycle.
  assign retire_valid = (count_q != '0) && ready_q[head_q];
  assign mispredict   = retire_valid && is_branch_q[head_q] &&
                        (actual_jump_q[head_q] != pred_jump_q[head_q]);
  assign flush        = mispredict;
  assign commit_ok    = retire_valid && !mispredict;
  assign alloc        = enable_sign_from_cmd && !full_to_cmd && !flush;

  assign cdb_m1       = rob_id_from_cdb - ROB_ID_W'(1);
  assign cdb_idx      = cdb_m1[PtrW-1:0];
  assign cdb_in_range = (rob_id_from_cdb != '0) && (cdb_m1 < ROB_ID_W'(ROB_SIZE));
  assign cdb_hit      = valid_from_cdb && cdb_in_range && busy_q[cdb_idx];

  assign qid[0] = query1_id_from_cmd;
  assign qid[1] = query2_id_from_cmd;

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      q_rdy[k] = 1'b0;
      q_val[k] = '0;
      q_m1[k]  = qid[k] - ROB_ID_W'(1);
      q_idx[k] = q_m1[k][PtrW-1:0];
      if (qid[k] != '0) begin
        if (valid_from_cdb && (rob_id_from_cdb == qid[k])) begin
          q_rdy[k] = 1'b1;
          q_val[k] = V_from_cdb;
        end else if (q_m1[k] < ROB_ID_W'(ROB_SIZE)) begin
          q_rdy[k] = busy_q[q_idx[k]] && ready_q[q_idx[k]];
          q_val[k] = v_q[q_idx[k]];
        end
      end
    end
  end

  assign query1_ready_to_cmd = q_rdy[0];
  assign query1_V_to_cmd     = q_val[0];
  assign query2_ready_to_cmd = q_rdy[1];
  assign query2_V_to_cmd     = q_val[1];

  always_comb begin
    head_d        = head_q;
    tail_d        = tail_q;
    count_d       = count_q;
    busy_d        = busy_q;
    ready_d       = ready_q;
    is_branch_d   = is_branch_q;
    pred_jump_d   = pred_jump_q;
    actual_jump_d = actual_jump_q;
    rd_d          = rd_q;
    alt_pc_d      = alt_pc_q;
    v_d           = v_q;
    commit_d      = 1'b0;
    rollback_d    = 1'b0;
    rd_reg_d      = rd_reg_q;
    v_reg_d       = v_reg_q;
    q_reg_d       = q_reg_q;
    target_pc_d   = target_pc_q;

    if (flush) begin
      // Same-cycle allocation and CDB write are dropped with the rest of the queue.
      head_d      = '0;
      tail_d      = '0;
      count_d     = '0;
      busy_d      = '0;
      ready_d     = '0;
      rollback_d  = 1'b1;
      target_pc_d = alt_pc_q[head_q];
    end else begin
      if (cdb_hit) begin
        ready_d[cdb_idx]       = 1'b1;
        v_d[cdb_idx]           = V_from_cdb;
        actual_jump_d[cdb_idx] = jump_from_cdb;
      end
      if (commit_ok) begin
        commit_d        = 1'b1;
        rd_reg_d        = is_branch_q[head_q] ? '0 : rd_q[head_q];
        v_reg_d         = v_q[head_q];
        q_reg_d         = ROB_ID_W'(head_q) + ROB_ID_W'(1);
        busy_d[head_q]  = 1'b0;
        ready_d[head_q] = 1'b0;
        head_d          = head_q + PtrW'(1);
      end
      if (alloc) begin
        busy_d[tail_q]      = 1'b1;
        ready_d[tail_q]     = 1'b0;
        rd_d[tail_q]        = rd_from_cmd;
        is_branch_d[tail_q] = is_branch_from_cmd;
        pred_jump_d[tail_q] = pred_jump_from_cmd;
        alt_pc_d[tail_q]    = alt_pc_from_cmd;
        tail_d              = tail_q + PtrW'(1);
      end
      unique case ({alloc, commit_ok})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      busy_q        <= '0;
      ready_q       <= '0;
      is_branch_q   <= '0;
      pred_jump_q   <= '0;
      actual_jump_q <= '0;
      for (int i = 0; i < ROB_SIZE; i++) begin
        rd_q[i]     <= '0;
        alt_pc_q[i] <= '0;
        v_q[i]      <= '0;
      end
      commit_q      <= 1'b0;
      rollback_q    <= 1'b0;
      rd_reg_q      <= '0;
      v_reg_q       <= '0;
      q_reg_q       <= '0;
      target_pc_q   <= '0;
    end else begin
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      busy_q        <= busy_d;
      ready_q       <= ready_d;
      is_branch_q   <= is_branch_d;
      pred_jump_q   <= pred_jump_d;
      actual_jump_q <= actual_jump_d;
      rd_q          <= rd_d;
      alt_pc_q      <= alt_pc_d;
      v_q           <= v_d;
      commit_q      <= commit_d;
      rollback_q    <= rollback_d;
      rd_reg_q      <= rd_reg_d;
      v_reg_q       <= v_reg_d;
      q_reg_q       <= q_reg_d;
      target_pc_q   <= target_pc_d;
    end
  end

  assign commit_sign_to_reg   = commit_q;
  assign rd_to_reg            = rd_reg_q;
  assign V_to_reg             = v_reg_q;
  assign Q_to_reg             = q_reg_q;
  assign rollback_sign_to_reg = rollback_q;
  assign target_pc_to_if      = target_pc_q;

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: reset, in-order retire, full/wrap, mispredict, query bypass.
module tb_reorder_buffer;

  logic        clk;
  logic        rst;
  logic        en;
  logic [4:0]  rd;
  logic        is_br;
  logic        pred;
  logic [31:0] alt_pc;
  logic [4:0]  rob_id;
  logic        full;
  logic [4:0]  q1_id, q2_id;
  logic        q1_rdy, q2_rdy;
  logic [31:0] q1_v, q2_v;
  logic        cdb_valid;
  logic [4:0]  cdb_id;
  logic [31:0] cdb_v;
  logic        cdb_jump;
  logic        commit;
  logic [4:0]  rd_reg;
  logic [31:0] v_reg;
  logic [4:0]  q_reg;
  logic        rollback;
  logic [31:0] target_pc;

  int checks = 0;
  int errors = 0;

  reorder_buffer #(
    .ROB_SIZE(16),
    .ROB_ID_W(5),
    .REG_W   (5)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .enable_sign_from_cmd(en),
    .rd_from_cmd         (rd),
    .is_branch_from_cmd  (is_br),
    .pred_jump_from_cmd  (pred),
    .alt_pc_from_cmd     (alt_pc),
    .rob_id_to_cmd       (rob_id),
    .full_to_cmd         (full),
    .query1_id_from_cmd  (q1_id),
    .query2_id_from_cmd  (q2_id),
    .query1_ready_to_cmd (q1_rdy),
    .query1_V_to_cmd     (q1_v),
    .query2_ready_to_cmd (q2_rdy),
    .query2_V_to_cmd     (q2_v),
    .valid_from_cdb      (cdb_valid),
    .rob_id_from_cdb     (cdb_id),
    .V_from_cdb          (cdb_v),
    .jump_from_cdb       (cdb_jump),
    .commit_sign_to_reg  (commit),
    .rd_to_reg           (rd_reg),
    .V_to_reg            (v_reg),
    .Q_to_reg            (q_reg),
    .rollback_sign_to_reg(rollback),
    .target_pc_to_if     (target_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; rd = '0; is_br = 1'b0; pred = 1'b0; alt_pc = '0;
    q1_id = '0; q2_id = '0; cdb_valid = 1'b0; cdb_id = '0; cdb_v = '0; cdb_jump = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_commit", 32'(commit), 32'd0);
    chk("rst_rollback", 32'(rollback), 32'd0);
    chk("rst_robid", 32'(rob_id), 32'd1);
    rst = 1'b0;

    // In-order retire with out-of-order completion
    @(negedge clk); en = 1'b1; rd = 5'd3; #1 chk("alloc_id1", 32'(rob_id), 32'd1);
    @(negedge clk); rd = 5'd4; #1 chk("alloc_id2", 32'(rob_id), 32'd2);
    @(negedge clk); rd = 5'd5; #1 chk("alloc_id3", 32'(rob_id), 32'd3);
    @(negedge clk); en = 1'b0; rd = '0; cdb_valid = 1'b1; cdb_id = 5'd3; cdb_v = 32'h33;
    @(negedge clk); cdb_id = 5'd1; cdb_v = 32'h11;
    @(negedge clk);
    chk("no_early_commit", 32'(commit), 32'd0);
    cdb_id = 5'd2; cdb_v = 32'h22;
    @(negedge clk); cdb_valid = 1'b0;
    chk("c1_commit", 32'(commit), 32'd1);
    chk("c1_rd", 32'(rd_reg), 32'd3);
    chk("c1_v", v_reg, 32'h11);
    chk("c1_q", 32'(q_reg), 32'd1);
    @(negedge clk);
    chk("c2_commit", 32'(commit), 32'd1);
    chk("c2_rd", 32'(rd_reg), 32'd4);
    chk("c2_v", v_reg, 32'h22);
    chk("c2_q", 32'(q_reg), 32'd2);
    @(negedge clk);
    chk("c3_commit", 32'(commit), 32'd1);
    chk("c3_rd", 32'(rd_reg), 32'd5);
    chk("c3_v", v_reg, 32'h33);
    chk("c3_q", 32'(q_reg), 32'd3);
    @(negedge clk);
    chk("c3_pulse_end", 32'(commit), 32'd0);
    chk("c3_rd_hold", 32'(rd_reg), 32'd5);
    chk("robid_after3", 32'(rob_id), 32'd4);

    // Reset mid-operation with five live entries and a commit pulse in flight
    for (int i = 0; i < 6; i++) begin
      en = 1'b1; rd = 5'(i + 1);
      if (i == 5) begin cdb_valid = 1'b1; cdb_id = 5'd4; cdb_v = 32'h44; end
      #1 chk("fill_id", 32'(rob_id), 32'(4 + i));
      @(negedge clk);
    end
    en = 1'b0; rd = '0; cdb_valid = 1'b0; #1 chk("fill_tail", 32'(rob_id), 32'd10);
    @(negedge clk);
    chk("pre_rst_commit", 32'(commit), 32'd1);
    chk("pre_rst_q", 32'(q_reg), 32'd4);
    chk("pre_rst_v", v_reg, 32'h44);
    rst = 1'b1; #1;
    chk("mid_rst_full", 32'(full), 32'd0);
    chk("mid_rst_commit", 32'(commit), 32'd0);
    chk("mid_rst_rollback", 32'(rollback), 32'd0);
    chk("mid_rst_robid", 32'(rob_id), 32'd1);
    chk("mid_rst_q", 32'(q_reg), 32'd0);
    chk("mid_rst_v", v_reg, 32'd0);
    @(negedge clk); rst = 1'b0;

    // Full and pointer wrap
    for (int i = 0; i < 16; i++) begin
      en = 1'b1; rd = 5'(i);
      #1 chk("wrap_id", 32'(rob_id), 32'(i + 1));
      chk("wrap_not_full", 32'(full), 32'd0);
      @(negedge clk);
    end
    chk("full_set", 32'(full), 32'd1);
    chk("full_robid", 32'(rob_id), 32'd1);
    rd = 5'd7;
    @(negedge clk);
    chk("full_ignore", 32'(full), 32'd1);
    chk("full_ignore_id", 32'(rob_id), 32'd1);
    cdb_valid = 1'b1; cdb_id = 5'd1; cdb_v = 32'h55;
    @(negedge clk); cdb_valid = 1'b0;
    chk("full_before_retire", 32'(full), 32'd1);
    @(negedge clk);
    chk("full_retire_commit", 32'(commit), 32'd1);
    chk("full_retire_q", 32'(q_reg), 32'd1);
    chk("full_retire_v", v_reg, 32'h55);
    chk("full_after_retire", 32'(full), 32'd0);
    chk("wrap_grant_id", 32'(rob_id), 32'd1);
    rd = 5'd9;
    @(negedge clk);
    chk("refull", 32'(full), 32'd1);
    chk("refull_id", 32'(rob_id), 32'd2);
    chk("refull_commit", 32'(commit), 32'd0);
    en = 1'b0; rd = '0;
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;

    // Mispredict: branch id 1 plus two younger entries
    en = 1'b1; is_br = 1'b1; pred = 1'b1; alt_pc = 32'h1000; rd = '0;
    #1 chk("br_id", 32'(rob_id), 32'd1);
    @(negedge clk); is_br = 1'b0; pred = 1'b0; alt_pc = '0; rd = 5'd6;
    @(negedge clk); rd = 5'd7;
    @(negedge clk); en = 1'b0; rd = '0; cdb_valid = 1'b1; cdb_id = 5'd1; cdb_jump = 1'b0;
    cdb_v = '0;
    @(negedge clk);
    chk("pre_flush_rollback", 32'(rollback), 32'd0);
    cdb_id = 5'd2; cdb_v = 32'h99; en = 1'b1; rd = 5'd8;
    #1 chk("pre_flush_id", 32'(rob_id), 32'd4);
    @(negedge clk); en = 1'b0; rd = '0; cdb_valid = 1'b0; cdb_id = '0; cdb_v = '0;
    chk("flush_rollback", 32'(rollback), 32'd1);
    chk("flush_target", target_pc, 32'h1000);
    chk("flush_no_commit", 32'(commit), 32'd0);
    chk("flush_robid", 32'(rob_id), 32'd1);
    @(negedge clk);
    chk("flush_pulse_end", 32'(rollback), 32'd0);
    chk("flush_target_hold", target_pc, 32'h1000);
    chk("flush_commit_after", 32'(commit), 32'd0);
    chk("flush_robid_after", 32'(rob_id), 32'd1);
    q1_id = 5'd2; #1 chk("flush_discard_cdb", 32'(q1_rdy), 32'd0);
    q1_id = '0;

    // Correctly predicted branch commits with rd forced to 0
    en = 1'b1; is_br = 1'b1; pred = 1'b0; alt_pc = 32'h2000; rd = 5'd9;
    @(negedge clk); en = 1'b0; is_br = 1'b0; alt_pc = '0; rd = '0;
    cdb_valid = 1'b1; cdb_id = 5'd1; cdb_jump = 1'b0; cdb_v = 32'h77;
    @(negedge clk); cdb_valid = 1'b0;
    @(negedge clk);
    chk("okbr_commit", 32'(commit), 32'd1);
    chk("okbr_rd", 32'(rd_reg), 32'd0);
    chk("okbr_q", 32'(q_reg), 32'd1);
    chk("okbr_v", v_reg, 32'h77);
    chk("okbr_rollback", 32'(rollback), 32'd0);

    // Query bypass on ids 2 and 3
    en = 1'b1; rd = 5'd10;
    @(negedge clk); rd = 5'd11;
    @(negedge clk); en = 1'b0; rd = '0;
    q1_id = 5'd2; q2_id = '0; cdb_valid = 1'b1; cdb_id = 5'd2; cdb_v = 32'hABCD;
    #1;
    chk("byp_q1_rdy", 32'(q1_rdy), 32'd1);
    chk("byp_q1_v", q1_v, 32'hABCD);
    chk("byp_q0_rdy", 32'(q2_rdy), 32'd0);
    q2_id = 5'd3; #1 chk("byp_q3_notready", 32'(q2_rdy), 32'd0);
    @(negedge clk); cdb_valid = 1'b0; cdb_id = '0; cdb_v = '0; q2_id = '0;
    #1;
    chk("reg_q1_rdy", 32'(q1_rdy), 32'd1);
    chk("reg_q1_v", q1_v, 32'hABCD);
    @(negedge clk);
    chk("byp_retire_commit", 32'(commit), 32'd1);
    chk("byp_retire_q", 32'(q_reg), 32'd2);
    chk("byp_retire_rd", 32'(rd_reg), 32'd10);
    chk("q_after_retire", 32'(q1_rdy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
